// File: rtl/mem_disp_scan.sv
// Display memory with a one-cycle host read/write port and a valid/ready scan-out engine.
// Define MEM_DISP_SCAN_CLEAR_EN to zero the whole array automatically after every reset.
module mem_disp_scan #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_valid,
  input  logic             scan_ready,
  output logic [WIDTH-1:0] scan_data,
  output logic [AW-1:0]    scan_addr,
  output logic             scan_last,
  output logic             clr_busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM
`ifdef MEM_DISP_SCAN_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t state, next_state;

  // NOTE: the array has no reset branch; a reset loop over every word would not map to RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic          in_range;
  logic          fire;
  logic          load_first;
  logic          advance;
  logic          finish;
  logic [AW-1:0] next_scan_addr;

  assign in_range       = {1'b0, addr} < (AW + 1)'(DEPTH);
  assign fire           = scan_valid && scan_ready;
  assign next_scan_addr = scan_addr + AW'(1);

`ifdef MEM_DISP_SCAN_CLEAR_EN
  logic [AW-1:0] clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   clr_addr <= '0;
    else if (state == S_CLEAR) clr_addr <= clr_addr + AW'(1);
  end

  assign clr_busy = (state == S_CLEAR);
`else
  assign clr_busy = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef MEM_DISP_SCAN_CLEAR_EN
      state <= S_CLEAR;
`else
      state <= S_IDLE;
`endif
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (scan_start) begin
          next_state = S_STREAM;
          load_first = 1'b1;
        end
      end
      S_STREAM: begin
        if (fire) begin
          if (scan_addr == LAST_ADDR) begin
            next_state = S_IDLE;
            finish     = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
`ifdef MEM_DISP_SCAN_CLEAR_EN
      S_CLEAR: begin
        if (clr_addr == LAST_ADDR) next_state = S_IDLE;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // The clear engine owns the write port while it runs; host writes are dropped.
  always_ff @(posedge clk) begin
`ifdef MEM_DISP_SCAN_CLEAR_EN
    if (state == S_CLEAR) mem[clr_addr] <= '0;
    else
`endif
    if (wr && in_range) mem[addr] <= d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           d_o <= '0;
    else if (in_range) d_o <= mem[addr];
    else               d_o <= '0;
  end

  // Scan fetches read the array before any same-edge write lands, so they see old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_valid <= 1'b0;
      scan_addr  <= '0;
      scan_data  <= '0;
    end else if (load_first) begin
      scan_valid <= 1'b1;
      scan_addr  <= '0;
      scan_data  <= mem[0];
    end else if (advance) begin
      scan_addr  <= next_scan_addr;
      scan_data  <= mem[next_scan_addr];
    end else if (finish) begin
      scan_valid <= 1'b0;
      scan_addr  <= '0;
    end
  end

  assign scan_busy = (state == S_STREAM);
  assign scan_last = scan_valid && (scan_addr == LAST_ADDR);

endmodule
